// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default widths, FSM encoding,
// and the iteration-counter width.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_16x8_if.sv
// Operand/result bundle between a requester and the sequential divider.
// start/operands flow to the divider; busy/done/results flow back.
interface seq_divider_16x8_if import div_pkg::*; #(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare/subtract.
// Purely combinational; no state, no backpressure.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] i_r,
  input  logic                 i_q_msb,
  input  logic [DIVISOR_W-1:0] i_d,
  output logic [DIVISOR_W-1:0] o_r,
  output logic                 o_q_bit
);

  logic [DIVISOR_W:0] w_t;
  logic [DIVISOR_W:0] w_diff;

  assign w_t    = {i_r, i_q_msb};
  assign w_diff = w_t - {1'b0, i_d};

  // T <= 2*D-1, so T-D lies in [-D, D-1]: the top bit of the wide difference is
  // set exactly when the subtraction would borrow.
  assign o_q_bit = ~w_diff[DIVISOR_W];
  assign o_r     = o_q_bit ? w_diff[DIVISOR_W-1:0] : w_t[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider, one quotient bit per clock; done pulses DIVIDEND_W+1
// clocks after an accepted start (1 clock for divide-by-zero); start ignored while busy.
module seq_divider_16x8 import div_pkg::*; #(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_divider_16x8_if.slave      div_if
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_r;
  logic [DIVISOR_W-1:0]  r_d;
  logic                  r_busy;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz;

  logic [DIVISOR_W-1:0]  w_r_next;
  logic                  w_q_bit;

  // Partial remainder is kept at DIVISOR_W bits because it always stays below D;
  // the extra compare bit lives inside the step.
  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[DIVIDEND_W-1]),
    .i_d     (r_d),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (div_if.start) begin
            if (div_if.divisor != '0) begin
              r_state <= ST_CALC;
              r_q     <= div_if.dividend;
              r_r     <= '0;
              r_d     <= div_if.divisor;
              r_cnt   <= CNT_W'(DIVIDEND_W - 1);
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_quot  <= '1;
              r_rem   <= div_if.dividend[DIVISOR_W-1:0];
              r_dbz   <= 1'b1;
            end
          end
        end

        ST_CALC: begin
          r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_quot  <= {r_q[DIVIDEND_W-2:0], w_q_bit};
            r_rem   <= w_r_next;
            r_dbz   <= 1'b0;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.busy        = r_busy;
  assign div_if.done        = r_done;
  assign div_if.quotient    = r_quot;
  assign div_if.remainder   = r_rem;
  assign div_if.div_by_zero = r_dbz;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(r_busy && r_done));
  a_done_one_cycle: assert property (@(posedge clk) disable iff (reset) r_done |=> !r_done);

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Randomized and directed checks of seq_divider_16x8 against a plain / and % model.
module tb_seq_divider_16x8;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_16x8_if bus ();

  seq_divider_16x8 dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic void model(input int dvd, input int dvs,
                                output int q, output int r, output int z);
    if (dvs == 0) begin
      q = 65535;
      r = dvd % 256;
      z = 1;
    end else begin
      q = dvd / dvs;
      r = dvd % dvs;
      z = 0;
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                        input int poke_at, output int done_cyc);
    int  q, r, z, lat;
    bit  got;
    model(int'(dvd), int'(dvs), q, r, z);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    chk("busy_after_accept", 32'(bus.busy), 32'(dvs != 0));
    chk("done_low_after_accept", 32'(bus.done), 32'(0));
    got = 1'b0;
    lat = 0;
    done_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        bus.start    = 1'b1;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom_range(1, 255));
      end else begin
        bus.start = 1'b0;
      end
      chk("busy_profile", 32'(bus.busy), 32'((dvs != 0) && (k <= 15)));
      chk("busy_done_excl", 32'(bus.busy & bus.done), 32'(0));
      if (bus.done) begin
        got = 1'b1;
        lat = k;
        done_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      chk("done_timeout", 32'(0), 32'(1));
    end else begin
      chk("latency", 32'(lat), 32'((dvs != 0) ? 17 : 1));
      chk("quotient", 32'(bus.quotient), 32'(q));
      chk("remainder", 32'(bus.remainder), 32'(r));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(z));
      if (dvs != 0) begin
        chk("rem_lt_divisor", 32'(bus.remainder < dvs), 32'(1));
        chk("q_times_d_plus_r", 32'(bus.quotient) * 32'(dvs) + 32'(bus.remainder), 32'(dvd));
      end
    end
  endtask

  initial begin
    int t1, t2, seen;
    logic [15:0] rd;
    logic [7:0]  rs;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_quotient", 32'(bus.quotient), 32'(0));
    chk("rst_remainder", 32'(bus.remainder), 32'(0));
    chk("rst_dbz", 32'(bus.div_by_zero), 32'(0));

    run_op(16'd1000, 8'd7, -1, t1);
    run_op(16'hFFFF, 8'hFF, -1, t1);
    run_op(16'hFFFF, 8'h01, -1, t1);
    run_op(16'd5, 8'd9, -1, t1);
    run_op(16'd0, 8'd1, -1, t1);
    run_op(16'h1234, 8'd0, -1, t1);
    run_op(16'd100, 8'd10, -1, t1);

    // Re-asserted start mid-calculation must not disturb the in-flight divide.
    run_op(16'd1000, 8'd7, 5, t1);

    // Reset during CALC aborts without a done pulse.
    bus.start    = 1'b1;
    bus.dividend = 16'd5000;
    bus.divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    chk("abort_quotient", 32'(bus.quotient), 32'(0));
    chk("abort_remainder", 32'(bus.remainder), 32'(0));
    chk("abort_dbz", 32'(bus.div_by_zero), 32'(0));
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'(0));

    // Back-to-back: second start issued in the cycle done is seen.
    run_op(16'd200, 8'd3, -1, t1);
    run_op(16'd255, 8'd16, -1, t2);
    chk("b2b_done_spacing", 32'(t2 - t1), 32'(18));

    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       rs = 8'd0;
        1:       rs = 8'd1;
        2:       rs = 8'hFF;
        default: rs = 8'($urandom_range(1, 255));
      endcase
      if ($urandom_range(0, 7) == 0) rd = 16'($urandom_range(0, 300));
      else                           rd = 16'($urandom);
      run_op(rd, rs, -1, t1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
